snitch_fp_ss_arbiter: RTL and testbench

- Shares one floating-point subsystem (accelerator-slave interface: request with addr/id/data_op/data_arga-c; response with id/data/error) between NrPorts core accelerator ports.
- Round-robin arbitration on the request side, with per-port outstanding-credit tracking.
- The requester index is embedded in the upper id bits, so responses are routed back to the correct port.
- Sits between core accelerator outputs and a single FP subsystem instance inside a tile.

---
 rtl/snitch_pkg.sv | 24 ++
 rtl/snitch_fp_rr_arb.sv | 29 ++
 rtl/snitch_fp_ss_arbiter.sv | 128 ++++++++++++
 tb/tb_snitch_fp_ss_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_pkg.sv
// Accelerator request/response types shared by the FP subsystem arbiter.
// The id field holds {port index, rd} and is sized for FpArbMaxPorts ports.
package snitch_pkg;

  localparam int FpArbMaxPorts = 8;
  localparam int AccRdWidth    = 5;
  localparam int AccIdWidth    = AccRdWidth + $clog2(FpArbMaxPorts);

  typedef struct packed {
    logic [31:0]           addr;
    logic [AccIdWidth-1:0] id;
    logic [31:0]           data_op;
    logic [63:0]           data_arga;
    logic [63:0]           data_argb;
    logic [63:0]           data_argc;
  } acc_req_t;

  typedef struct packed {
    logic [AccIdWidth-1:0] id;
    logic [63:0]           data;
    logic                  error;
  } acc_resp_t;

endpackage

// File: rtl/snitch_fp_rr_arb.sv
// Combinational round-robin pick: first eligible port at or after ptr_i, wrapping.
module snitch_fp_rr_arb #(
  parameter  int NrPorts  = 4,
  localparam int IdxWidth = $clog2(NrPorts)
) (
  input  logic [NrPorts-1:0]  eligible_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NrPorts-1:0]  gnt_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  always_comb begin
    int j;
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int i = 0; i < NrPorts; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NrPorts) j = j - NrPorts;
      if (!valid_o && eligible_i[j]) begin
        valid_o = 1'b1;
        idx_o   = IdxWidth'(j);
      end
    end
    gnt_o = valid_o ? (NrPorts'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/snitch_fp_ss_arbiter.sv
// Shares one FP subsystem between NrPorts cores: round-robin requests, credit-limited,
// responses routed by the port index in the upper id bits.
// Optional SNITCH_FP_ARB_PERF_EN adds per-port grant/stall counters.
module snitch_fp_ss_arbiter
  import snitch_pkg::*;
#(
  parameter  int NrPorts        = 4,
  parameter  int RdWidth        = 5,
  parameter  int MaxOutstanding = 4,
  localparam int IdxWidth       = $clog2(NrPorts)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  acc_req_t  [NrPorts-1:0]     core_req_i,
  input  logic      [NrPorts-1:0]     core_req_valid_i,
  output logic      [NrPorts-1:0]     core_req_ready_o,
  output acc_resp_t [NrPorts-1:0]     core_resp_o,
  output logic      [NrPorts-1:0]     core_resp_valid_o,
  input  logic      [NrPorts-1:0]     core_resp_ready_i,
  output acc_req_t                    fpss_req_o,
  output logic                        fpss_req_valid_o,
  input  logic                        fpss_req_ready_i,
  input  acc_resp_t                   fpss_resp_i,
  input  logic                        fpss_resp_valid_i,
  output logic                        fpss_resp_ready_o,
  output logic      [NrPorts-1:0]     busy_o
`ifdef SNITCH_FP_ARB_PERF_EN
  ,
  output logic      [NrPorts-1:0][31:0] grant_cnt_o,
  output logic      [NrPorts-1:0][31:0] stall_cnt_o
`endif
);

  localparam int UpWidth = AccIdWidth - RdWidth;

  logic [NrPorts-1:0][3:0]  r_cnt;
  logic [IdxWidth-1:0]      r_ptr;
  logic [NrPorts-1:0]       w_elig, w_gnt, w_req_hs, w_resp_hs;
  logic [IdxWidth-1:0]      w_gidx;
  logic                     w_gvld;
  logic [UpWidth-1:0]       w_ridx;
  logic [IdxWidth-1:0]      w_rport;
  logic                     w_route;

  always_comb begin
    for (int p = 0; p < NrPorts; p++)
      w_elig[p] = !rst_i && core_req_valid_i[p] && (r_cnt[p] < 4'(MaxOutstanding));
  end

  snitch_fp_rr_arb #(.NrPorts(NrPorts)) i_rr_arb (
    .eligible_i (w_elig),
    .ptr_i      (r_ptr),
    .gnt_o      (w_gnt),
    .idx_o      (w_gidx),
    .valid_o    (w_gvld)
  );

  assign fpss_req_valid_o = w_gvld;
  assign core_req_ready_o = w_gnt & {NrPorts{fpss_req_ready_i}};
  assign w_req_hs         = core_req_ready_o;

  always_comb begin
    fpss_req_o                         = core_req_i[w_gidx];
    fpss_req_o.id                      = '0;
    fpss_req_o.id[RdWidth +: IdxWidth] = w_gidx;
    fpss_req_o.id[RdWidth-1:0]         = core_req_i[w_gidx].id[RdWidth-1:0];
  end

  // An index outside the port range or a port with no credit out is a stray response:
  // it is accepted and swallowed so the subsystem never blocks on it.
  assign w_ridx  = fpss_resp_i.id[AccIdWidth-1:RdWidth];
  assign w_rport = IdxWidth'(w_ridx);
  assign w_route = !rst_i && (int'(w_ridx) < NrPorts) && (r_cnt[w_rport] != 4'd0);

  assign fpss_resp_ready_o = rst_i ? 1'b0 : (w_route ? core_resp_ready_i[w_rport] : 1'b1);

  always_comb begin
    for (int p = 0; p < NrPorts; p++) begin
      core_resp_o[p]       = fpss_resp_i;
      core_resp_o[p].id    = AccIdWidth'(fpss_resp_i.id[RdWidth-1:0]);
      core_resp_valid_o[p] = fpss_resp_valid_i && w_route && (w_rport == IdxWidth'(p));
      busy_o[p]            = !rst_i && (r_cnt[p] != 4'd0);
    end
  end

  assign w_resp_hs = core_resp_valid_o & core_resp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_ptr <= '0;
    end else begin
      for (int p = 0; p < NrPorts; p++) begin
        if (w_req_hs[p] && !w_resp_hs[p])      r_cnt[p] <= r_cnt[p] + 4'd1;
        else if (!w_req_hs[p] && w_resp_hs[p]) r_cnt[p] <= r_cnt[p] - 4'd1;
      end
      if (|w_req_hs)
        r_ptr <= (int'(w_gidx) == NrPorts-1) ? '0 : w_gidx + IdxWidth'(1);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && fpss_resp_valid_i)
      assert (w_route) else $warning("snitch_fp_ss_arbiter: stray response id %0h dropped", fpss_resp_i.id);
  end
`endif

`ifdef SNITCH_FP_ARB_PERF_EN
  logic [NrPorts-1:0][31:0] r_grant_cnt, r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int p = 0; p < NrPorts; p++) begin
        if (w_req_hs[p])                        r_grant_cnt[p] <= r_grant_cnt[p] + 32'd1;
        if (core_req_valid_i[p] && !w_gnt[p])   r_stall_cnt[p] <= r_stall_cnt[p] + 32'd1;
      end
    end
  end

  assign grant_cnt_o = r_grant_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_snitch_fp_ss_arbiter.sv
// Directed + random bench for snitch_fp_ss_arbiter against a credit/queue reference model.
module tb_snitch_fp_ss_arbiter;
  import snitch_pkg::*;

  localparam int N = 4;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst;
  acc_req_t  [N-1:0] core_req;
  logic      [N-1:0] req_v, req_rdy;
  acc_resp_t [N-1:0] core_resp;
  logic      [N-1:0] resp_v, resp_rdy;
  acc_req_t          fpss_req;
  logic              fv, fready;
  acc_resp_t         fresp;
  logic              frv, frr;
  logic      [N-1:0] busy;
`ifdef SNITCH_FP_ARB_PERF_EN
  logic [N-1:0][31:0] grant_cnt, stall_cnt;
`endif

  snitch_fp_ss_arbiter #(.NrPorts(N), .RdWidth(5), .MaxOutstanding(MO)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .core_req_i        (core_req),
    .core_req_valid_i  (req_v),
    .core_req_ready_o  (req_rdy),
    .core_resp_o       (core_resp),
    .core_resp_valid_o (resp_v),
    .core_resp_ready_i (resp_rdy),
    .fpss_req_o        (fpss_req),
    .fpss_req_valid_o  (fv),
    .fpss_req_ready_i  (fready),
    .fpss_resp_i       (fresp),
    .fpss_resp_valid_i (frv),
    .fpss_resp_ready_o (frr),
    .busy_o            (busy)
`ifdef SNITCH_FP_ARB_PERF_EN
    ,
    .grant_cnt_o       (grant_cnt),
    .stall_cnt_o       (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: credits per port, rr pointer, FIFO of ids in the FP subsystem
  int        m_cnt[N];
  int        m_ptr;
  logic [7:0] pend[$];
  bit        resp_from_pend;
  int        e_g, e_ridx;
  bit        e_route;
  logic [N-1:0] e_rv;
  logic      e_frr;
  int        gcount[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    logic [N-1:0] e_rdy, e_busy;
    #2;
    e_g = -1;
    if (!rst)
      for (int i = 0; i < N; i++) begin
        int p;
        p = (m_ptr + i) % N;
        if (e_g < 0 && req_v[p] && m_cnt[p] < MO) e_g = p;
      end
    chk("req_valid", 64'(fv), 64'(e_g >= 0));
    if (e_g >= 0) begin
      chk("req_id", 64'(fpss_req.id), 64'(e_g * 32 + int'(core_req[e_g].id[4:0])));
      chk("req_op", 64'(fpss_req.data_op), 64'(core_req[e_g].data_op));
    end
    e_rdy = (e_g >= 0 && fready) ? N'(1 << e_g) : '0;
    chk("req_ready", 64'(req_rdy), 64'(e_rdy));
    for (int p = 0; p < N; p++) e_busy[p] = !rst && m_cnt[p] != 0;
    chk("busy", 64'(busy), 64'(e_busy));
    e_ridx  = int'(fresp.id) >> 5;
    e_route = !rst && e_ridx < N && m_cnt[e_ridx] > 0;
    e_rv    = (frv && e_route) ? N'(1 << e_ridx) : '0;
    chk("resp_valid", 64'(resp_v), 64'(e_rv));
    e_frr   = rst ? 1'b0 : (e_route ? resp_rdy[e_ridx] : 1'b1);
    chk("resp_ready", 64'(frr), 64'(e_frr));
    if (e_rv != 0) begin
      chk("resp_id", 64'(core_resp[e_ridx].id), 64'(fresp.id & 8'h1f));
      chk("resp_data", core_resp[e_ridx].data, fresp.data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (frv && e_frr && resp_from_pend) void'(pend.pop_front());
    if (rst) begin
      for (int p = 0; p < N; p++) m_cnt[p] = 0;
      m_ptr = 0;
    end else begin
      if (e_g >= 0 && fready) begin
        m_cnt[e_g]++;
        m_ptr = (e_g + 1) % N;
        pend.push_back(8'(e_g * 32 + int'(core_req[e_g].id[4:0])));
      end
      if (e_rv != 0 && resp_rdy[e_ridx]) m_cnt[e_ridx]--;
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic set_resp(input bit en);
    if (en && pend.size() > 0) begin
      frv = 1'b1;
      fresp.id = pend[0];
      fresp.data = {$urandom, $urandom};
      fresp.error = 1'($urandom);
      resp_from_pend = 1'b1;
    end else begin
      frv = 1'b0;
      resp_from_pend = 1'b0;
    end
  endtask

  task automatic drain();
    req_v = '0;
    resp_rdy = '1;
    for (int k = 0; k < 40 && pend.size() > 0; k++) begin
      set_resp(1'b1);
      step();
    end
    set_resp(1'b0);
    chk("drain_empty", 64'(pend.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int p = 0; p < N; p++) begin
      m_cnt[p] = 0;
      core_req[p] = '0;
      core_req[p].data_op = 32'h100 + p;
      gcount[p] = 0;
    end
    m_ptr = 0;
    rst = 1'b1; req_v = '0; resp_rdy = '0; fready = 1'b0;
    fresp = '0; frv = 1'b0; resp_from_pend = 1'b0;
    @(posedge clk); #1;

    // reset state, with requests and a response presented
    req_v = 4'b1111; fready = 1'b1; frv = 1'b1; fresp.id = 8'h20;
    settle();
    chk("rst_fv", 64'(fv), 64'd0);
    chk("rst_frr", 64'(frr), 64'd0);
    tick();
    step();
    rst = 1'b0; req_v = '0; frv = 1'b0;

    // single op on port 2, rd = 3
    req_v = 4'b0100; core_req[2].id = 8'h03;
    settle();
    chk("p2_id", 64'(fpss_req.id), 64'h43);
    tick();
    req_v = '0;
    settle();
    chk("p2_busy", 64'(busy), 64'b0100);
    tick();
    frv = 1'b1; fresp.id = 8'h43; fresp.data = 64'hDEAD_BEEF; resp_from_pend = 1'b1; resp_rdy = '1;
    settle();
    chk("p2_rv", 64'(resp_v), 64'b0100);
    chk("p2_rid", 64'(core_resp[2].id), 64'd3);
    tick();
    set_resp(1'b0);
    settle();
    chk("p2_busy_clr", 64'(busy), 64'd0);
    tick();

    // all ports valid, immediate responses: strict rotation starting at port 3
    for (int p = 0; p < N; p++) core_req[p].id = 8'(p + 1);
    req_v = 4'b1111;
    for (int i = 0; i < 100; i++) begin
      set_resp(1'b1);
      settle();
      chk("rr_order", 64'(fpss_req.id[7:5]), 64'((3 + i) % N));
      gcount[int'(fpss_req.id[7:5])]++;
      tick();
    end
    for (int p = 0; p < N; p++) chk("rr_fair", 64'(gcount[p]), 64'd25);
    drain();

    // port 1 runs out of credits
    req_v = 4'b0010;
    for (int i = 0; i < MO; i++) step();
    req_v = 4'b1010;
    settle();
    chk("mask_p3", 64'(req_rdy), 64'b1000);
    tick();
    req_v = 4'b0010; set_resp(1'b1);
    settle();
    chk("mask_same_cycle", 64'(req_rdy), 64'd0);
    tick();
    set_resp(1'b0);
    settle();
    chk("unmask", 64'(req_rdy), 64'b0010);
    tick();
    drain();

    // downstream stall: grant holds on port 0
    req_v = 4'b1000; step(); drain();
    core_req[0].data_op = 32'hC0FFEE00;
    req_v = 4'b0101; fready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_gnt", 64'(fpss_req.id[7:5]), 64'd0);
      chk("stall_op", 64'(fpss_req.data_op), 64'hC0FFEE00);
      tick();
    end
    fready = 1'b1;
    settle(); chk("rel_p0", 64'(req_rdy), 64'b0001); tick();
    settle(); chk("rel_p2", 64'(req_rdy), 64'b0100); tick();
    drain();

    // simultaneous request and response on port 0 at cnt = 2
    req_v = 4'b0001; step(); step();
    set_resp(1'b1); step();
    req_v = '0; set_resp(1'b1); step();
    set_resp(1'b0);
    settle(); chk("same_cyc_cnt1", 64'(busy), 64'b0001); tick();
    set_resp(1'b1); step();
    set_resp(1'b0);
    settle(); chk("same_cyc_cnt0", 64'(busy), 64'd0); tick();

    // out-of-range index is swallowed
    frv = 1'b1; fresp.id = 8'hA3; resp_from_pend = 1'b0; resp_rdy = '0;
    settle();
    chk("stray_ready", 64'(frr), 64'd1);
    chk("stray_fwd", 64'(resp_v), 64'd0);
    tick();
    frv = 1'b0;

    // reset with three requests outstanding
    req_v = 4'b0111;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    settle();
    chk("mid_rst_fv", 64'(fv), 64'd0);
    chk("mid_rst_rdy", 64'(req_rdy), 64'd0);
    tick();
    rst = 1'b0; req_v = '0;
    settle();
    chk("post_rst_busy", 64'(busy), 64'd0);
`ifdef SNITCH_FP_ARB_PERF_EN
    chk("perf_grant_clr", 64'(|grant_cnt), 64'd0);
    chk("perf_stall_clr", 64'(|stall_cnt), 64'd0);
`endif
    tick();
    resp_rdy = '1; set_resp(1'b1);
    settle();
    chk("stale_ready", 64'(frr), 64'd1);
    chk("stale_fwd", 64'(resp_v), 64'd0);
    tick();
    set_resp(1'b0);
    pend.delete();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      req_v = N'($urandom);
      for (int p = 0; p < N; p++) begin
        core_req[p].id      = 8'($urandom);
        core_req[p].data_op = $urandom;
        core_req[p].addr    = $urandom;
      end
      fready   = ($urandom_range(0, 3) != 0);
      resp_rdy = N'($urandom);
      set_resp($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
